// File: rtl/pov_pkg.sv
// Shared definitions for the persistence-of-vision pipeline (revolution timer and theta stage).
package pov_pkg;

  localparam int POV_CLK_HZ       = 24_000_000;
  localparam int POV_PERIOD_WIDTH = 24;

  typedef enum logic [1:0] {
    S_WAIT_FIRST = 2'd0,
    S_MEASURE    = 2'd1,
    S_LOCKED     = 2'd2
  } rev_state_t;

endpackage

// File: rtl/ir_input_filter.sv
// IR input conditioning: synchronizer, polarity normalize, MIN_HIGH run-length glitch filter.
// Level changes SYNC_STAGES+MIN_HIGH-1 edges after the first qualifying sample; no backpressure.
module ir_input_filter #(
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_HIGH       = 16,
  parameter bit IR_ACTIVE_HIGH = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_ir,
  output logic o_level,
  output logic o_rise
);

  localparam int              CW      = $clog2(MIN_HIGH + 1);
  localparam logic [CW-1:0]   LP_LAST = CW'(MIN_HIGH - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_run;
  logic                   r_level;
  logic                   r_rise;
  logic                   w_act;

  assign w_act = IR_ACTIVE_HIGH ? r_sync[SYNC_STAGES-1] : ~r_sync[SYNC_STAGES-1];

  // r_run counts consecutive samples disagreeing with the current qualified level.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sync  <= '0;
      r_run   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ir};
      r_rise <= 1'b0;
      if (w_act == r_level) begin
        r_run <= '0;
      end else if (r_run == LP_LAST) begin
        r_run   <= '0;
        r_level <= w_act;
        r_rise  <= w_act;
      end else begin
        r_run <= r_run + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/ir_rev_timer.sv
// Revolution timer: filters the IR trip, measures period, reports index/lock/stall.
// index_pulse lands SYNC_STAGES+MIN_HIGH cycles after the first active sample; strobes only, no backpressure.
module ir_rev_timer
  import pov_pkg::*;
#(
  parameter int PERIOD_WIDTH   = POV_PERIOD_WIDTH,
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_HIGH       = 16,
  parameter int MIN_PERIOD     = POV_CLK_HZ / 100,
  parameter int STALL_CYCLES   = (1 << POV_PERIOD_WIDTH) - 1,
  parameter int TOL_SHIFT      = 3,
  parameter bit IR_ACTIVE_HIGH = 1'b1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    ir_tripped,
  output logic                    index_pulse,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    locked,
  output logic                    stalled,
  output logic [15:0]             rev_count
);

  localparam int                    DW       = PERIOD_WIDTH + 1;
  localparam logic [PERIOD_WIDTH-1:0] LP_STALL = PERIOD_WIDTH'(STALL_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] LP_MINP  = PERIOD_WIDTH'(MIN_PERIOD);

  rev_state_t              r_state;
  rev_state_t              w_state_nxt;
  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic [PERIOD_WIDTH-1:0] r_prev;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic                    r_prev_vld;
  logic                    r_index;
  logic                    r_pvld;
  logic                    r_locked;
  logic                    r_stalled;
  logic [15:0]             r_rev;

  logic                    w_qual_level;
  logic                    w_qual_rise;
  logic                    w_trip;
  logic                    w_stall_hit;
  logic                    w_first;
  logic                    w_accept;
  logic                    w_in_tol;
  logic signed [DW-1:0]    w_diff;
  logic [DW-1:0]           w_abs;
  logic [DW-1:0]           w_tol;

  ir_input_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .MIN_HIGH       (MIN_HIGH),
    .IR_ACTIVE_HIGH (IR_ACTIVE_HIGH)
  ) u_filter (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_ir    (ir_tripped),
    .o_level (w_qual_level),
    .o_rise  (w_qual_rise)
  );

  assign w_trip   = w_qual_rise & w_qual_level;
  assign w_diff   = $signed({1'b0, r_cnt}) - $signed({1'b0, r_prev});
  assign w_abs    = w_diff[DW-1] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_tol    = {1'b0, r_prev >> TOL_SHIFT};
  assign w_in_tol = r_prev_vld && (w_abs <= w_tol);

  // A trip landing on the stall cycle is treated as the first trip of a new run.
  assign w_stall_hit = (r_state != S_WAIT_FIRST) && (r_cnt == LP_STALL);
  assign w_first     = (r_state == S_WAIT_FIRST) || w_stall_hit;
  assign w_accept    = w_trip && (w_first || (r_cnt >= LP_MINP));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_WAIT_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (w_first)       w_state_nxt = S_MEASURE;
      else if (w_in_tol) w_state_nxt = S_LOCKED;
      else               w_state_nxt = S_MEASURE;
    end else if (w_stall_hit) begin
      w_state_nxt = S_WAIT_FIRST;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt      <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_period   <= '0;
      r_index    <= 1'b0;
      r_pvld     <= 1'b0;
      r_locked   <= 1'b0;
      r_stalled  <= 1'b1;
      r_rev      <= '0;
    end else begin
      r_index  <= w_accept;
      r_pvld   <= w_accept && !w_first;
      r_locked <= (w_state_nxt == S_LOCKED);
      if (w_accept) begin
        r_cnt <= PERIOD_WIDTH'(1);
        r_rev <= r_rev + 16'd1;
      end else if (r_cnt != LP_STALL) begin
        r_cnt <= r_cnt + PERIOD_WIDTH'(1);
      end
      if (w_accept && w_first) begin
        r_prev_vld <= 1'b0;
        r_stalled  <= 1'b0;
      end else if (w_accept) begin
        r_period   <= r_cnt;
        r_prev     <= r_cnt;
        r_prev_vld <= 1'b1;
      end else if (w_stall_hit) begin
        r_prev_vld <= 1'b0;
        r_stalled  <= 1'b1;
      end
    end
  end

  assign index_pulse  = r_index;
  assign period       = r_period;
  assign period_valid = r_pvld;
  assign locked       = r_locked;
  assign stalled      = r_stalled;
  assign rev_count    = r_rev;

endmodule
